// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO push-side arbiter.
package fifo_arb_pkg;

  localparam int unsigned FIFO_ARB_DATA_W = 88;
  localparam int unsigned FIFO_ARB_DEPTH  = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Next index in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, with wrap-around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  // Scan the ring once starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_valid && req[ID_W'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter for a shared register FIFO, with per-packet lock.
// Optional build macro FIFO_ARB_HIPRI_EN: requester 0 becomes strict high
// priority in IDLE and its wins leave the round-robin pointer untouched.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned DATA_W     = FIFO_ARB_DATA_W,
  parameter int unsigned FIFO_DEPTH = FIFO_ARB_DEPTH
) (
  input  logic                        clockCore,
  input  logic                        resetCore,
  input  logic [NUM_REQ-1:0]          reqValid,
  input  logic [NUM_REQ-1:0]          reqLast,
  input  logic [NUM_REQ*DATA_W-1:0]   reqData,
  output logic [NUM_REQ-1:0]          reqReady,
  output logic                        fifoPush,
  output logic [DATA_W-1:0]           fifoDataIn,
  input  logic [$clog2(FIFO_DEPTH):0] fifoDepth,
  input  logic                        fifoOverrun,
  output logic [ID_W-1:0]             owner,
  output logic                        locked,
  output logic                        errOverrun
);

  // One extra bit over the occupancy width so an over-full reading goes negative.
  localparam int unsigned SPACE_W = $clog2(FIFO_DEPTH) + 2;

  arb_state_e          state;
  arb_state_e          next_state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     next_ptr;
  logic [ID_W-1:0]     next_owner;
  logic [SPACE_W-1:0]  space;
  logic                has_space;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic                sel_valid;
  logic [ID_W-1:0]     sel_id;
  logic                sel_last;
  logic                xfer;
  logic                advance;
  logic [DATA_W-1:0]   beats [NUM_REQ];
  logic [DATA_W-1:0]   sel_data;

  // Split the flat data bus into per-requester beats.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_beats
    assign beats[g] = reqData[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (reqValid),
    .ptr       (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // Conservative free space: an in-flight push counts as occupied, pops are ignored.
  always_comb begin
    space     = SPACE_W'(FIFO_DEPTH) - SPACE_W'(fifoDepth) - SPACE_W'(fifoPush);
    has_space = !space[SPACE_W-1] && (space != '0);
  end

  // Candidate selection and the combinational ready/transfer decode.
  always_comb begin
    sel_valid = pick_valid;
    sel_id    = pick_id;
    if (state == ARB_LOCKED) begin
      sel_valid = 1'b1;
      sel_id    = owner;
    end
`ifdef FIFO_ARB_HIPRI_EN
    else if (reqValid[0]) begin
      sel_valid = 1'b1;
      sel_id    = '0;
    end
`endif
    reqReady = '0;
    if (sel_valid && has_space) reqReady[sel_id] = 1'b1;
    xfer     = sel_valid && has_space && reqValid[sel_id];
    sel_last = reqLast[sel_id];
    sel_data = beats[sel_id];
`ifdef FIFO_ARB_HIPRI_EN
    advance  = (sel_id != '0);
`else
    advance  = 1'b1;
`endif
  end

  // Next-state logic: lock on a non-last beat, release and rotate on the last beat.
  always_comb begin
    next_state = state;
    next_owner = owner;
    next_ptr   = rr_ptr;
    if (xfer) begin
      next_owner = sel_id;
      if (sel_last) begin
        next_state = ARB_IDLE;
        if (advance) next_ptr = ID_W'(wrap_inc(32'(sel_id), NUM_REQ));
      end else begin
        next_state = ARB_LOCKED;
      end
    end
  end

  // State register.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) state <= ARB_IDLE;
    else           state <= next_state;
  end

  // Registered FIFO push, data, owner and round-robin pointer.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      fifoPush   <= 1'b0;
      fifoDataIn <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
    end else begin
      fifoPush <= xfer;
      if (xfer) fifoDataIn <= sel_data;
      owner    <= next_owner;
      rr_ptr   <= next_ptr;
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore)        errOverrun <= 1'b0;
    else if (fifoOverrun) errOverrun <= 1'b1;
  end

  assign locked = (state == ARB_LOCKED);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized scoreboard bench for fifo_push_arbiter with a behavioural FIFO and arbiter model.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DATA_W  = FIFO_ARB_DATA_W;
  localparam int unsigned DEPTH   = FIFO_ARB_DEPTH;
`ifdef FIFO_ARB_HIPRI_EN
  localparam bit HIPRI = 1'b1;
`else
  localparam bit HIPRI = 1'b0;
`endif

  logic                      clockCore = 1'b0;
  logic                      resetCore;
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqReady;
  logic                      fifoPush;
  logic [DATA_W-1:0]         fifoDataIn;
  logic [4:0]                fifoDepth;
  logic                      fifoOverrun;
  logic [ID_W-1:0]           owner;
  logic                      locked;
  logic                      errOverrun;

  fifo_push_arbiter dut (
    .clockCore   (clockCore),
    .resetCore   (resetCore),
    .reqValid    (reqValid),
    .reqLast     (reqLast),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .fifoPush    (fifoPush),
    .fifoDataIn  (fifoDataIn),
    .fifoDepth   (fifoDepth),
    .fifoOverrun (fifoOverrun),
    .owner       (owner),
    .locked      (locked),
    .errOverrun  (errOverrun)
  );

  always #5 clockCore = ~clockCore;

  typedef struct packed {
    logic              push;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  int              occ;        // FIFO occupancy
  bit              pop_now;    // pop presented to the FIFO this cycle
  bit              cur_push;   // push the DUT should be showing this cycle
  bit              m_locked;
  int              m_owner;
  int              m_ptr;
  bit              m_err;
  logic [DATA_W-1:0] last_data;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT's push/data must match the next scoreboard entry.
  always @(negedge clockCore) begin
    if (mon_en) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_out: no expected entry, got push=%0b data=%h", fifoPush, fifoDataIn);
      end else begin
        e = exp_q.pop_front();
        if (fifoPush !== e.push || fifoDataIn !== e.data) begin
          errors++;
          $display("FAIL fifo_out: got push=%0b data=%h expected push=%0b data=%h at %0t",
                   fifoPush, fifoDataIn, e.push, e.data, $time);
        end
      end
    end
  end

  // FIFO and flag effects of the rising edge just taken.
  task automatic edge_update();
    if (cur_push) occ++;
    if (pop_now && occ > 0) occ--;
    if (fifoOverrun && !resetCore) m_err = 1'b1;
  endtask

  // One cycle: drive at posedge+1, evaluate model at negedge, end at next posedge+1.
  task automatic cycle(input int vp, input int lp, input int pp, input int op);
    logic [95:0] rnd;
    int          sel;
    int          space;
    logic [NUM_REQ-1:0] want_ready;
    bit          xfer;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValid[i] = ($urandom_range(99) < vp);
      reqLast[i]  = ($urandom_range(99) < lp);
      rnd = {$urandom(), $urandom(), $urandom()};
      reqData[i*DATA_W +: DATA_W] = rnd[DATA_W-1:0];
    end
    pop_now     = ($urandom_range(99) < pp);
    fifoOverrun = ($urandom_range(999) < op);
    fifoDepth   = 5'(occ);
    @(negedge clockCore);
    space      = int'(DEPTH) - occ - int'(cur_push);
    want_ready = '0;
    sel        = -1;
    if (m_locked) begin
      sel = m_owner;
    end else if (HIPRI && reqValid[0]) begin
      sel = 0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (sel < 0 && reqValid[(m_ptr + k) % NUM_REQ]) sel = (m_ptr + k) % NUM_REQ;
    end
    if (sel >= 0 && space >= 1) want_ready[sel] = 1'b1;
    chk("reqReady", 128'(reqReady), 128'(want_ready));
    chk("owner", 128'(owner), 128'(m_owner));
    chk("locked", 128'(locked), 128'(m_locked));
    chk("errOverrun", 128'(errOverrun), 128'(m_err));
    xfer = (sel >= 0) && want_ready[sel] && reqValid[sel];
    if (xfer) begin
      last_data = reqData[sel*DATA_W +: DATA_W];
      m_owner   = sel;
      if (reqLast[sel]) begin
        m_locked = 1'b0;
        if (!(HIPRI && sel == 0)) m_ptr = (sel + 1) % NUM_REQ;
      end else begin
        m_locked = 1'b1;
      end
    end
    exp_q.push_back({xfer, last_data});
    @(posedge clockCore);
    cur_push = xfer;
    edge_update();
    #1;
  endtask

  // Reset pulse starting at posedge+1; checks the asynchronous clear, then reseeds the model.
  task automatic do_reset();
    mon_en      = 1'b0;
    resetCore   = 1'b1;
    reqValid    = '0;
    reqLast     = '0;
    pop_now     = 1'b0;
    fifoOverrun = 1'b0;
    cur_push    = 1'b0;
    #1;
    chk("rst_fifoPush", 128'(fifoPush), 128'(0));
    chk("rst_fifoDataIn", 128'(fifoDataIn), 128'(0));
    chk("rst_locked", 128'(locked), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_errOverrun", 128'(errOverrun), 128'(0));
    chk("rst_reqReady", 128'(reqReady), 128'(0));
    repeat (2) begin
      @(posedge clockCore);
      edge_update();
    end
    #1;
    resetCore = 1'b0;
    m_locked  = 1'b0;
    m_owner   = 0;
    m_ptr     = 0;
    m_err     = 1'b0;
    last_data = '0;
    exp_q.delete();
    exp_q.push_back('0);
    mon_en    = 1'b1;
  endtask

  initial begin
    int guard;
    resetCore   = 1'b1;
    reqValid    = '0;
    reqLast     = '0;
    reqData     = '0;
    fifoDepth   = '0;
    fifoOverrun = 1'b0;
    occ         = 0;
    pop_now     = 1'b0;
    cur_push    = 1'b0;
    m_err       = 1'b0;
    @(posedge clockCore);
    #1;
    do_reset();

    // Mixed traffic with moderate draining.
    repeat (400) cycle(60, 50, 50, 0);
    // Heavy offered load, slow drain: FIFO fills and backpressure holds.
    repeat (300) cycle(90, 30, 10, 0);
    // No drain at all: full FIFO must stall every requester.
    repeat (100) cycle(100, 40, 0, 0);
    // Continuous single-beat packets, FIFO drained every cycle: strict rotation.
    repeat (300) cycle(100, 100, 100, 0);
    // Long packets with drops of valid mid-packet.
    repeat (300) cycle(50, 15, 60, 0);

    // Reset while a packet is locked.
    guard = 0;
    while (!m_locked && guard < 200) begin
      cycle(80, 10, 50, 0);
      guard++;
    end
    chk("lock_before_reset", 128'(m_locked), 128'(1));
    do_reset();
    repeat (300) cycle(70, 40, 50, 0);

    // Occasional overrun pulses: sticky flag.
    repeat (300) cycle(70, 50, 50, 8);
    repeat (50)  cycle(70, 50, 50, 0);
    do_reset();
    repeat (200) cycle(70, 50, 40, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
